// File: rtl/dr32e_bp_accuracy_monitor.sv
// dr32e branch-prediction accuracy monitor.
// Watches fetch for control-transfer instructions and keeps the prediction made
// for each one in an in-order FIFO. When execute resolves the instruction at the
// head, the prediction is scored. The block only observes the pipeline and
// drives nothing back into it.
module dr32e_bp_accuracy_monitor #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 32,
  parameter int OCC_W = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [31:0]      fetch_rdata_i,
  input  logic [31:0]      fetch_pc_i,
  input  logic             fetch_valid_i,
  input  logic             predict_branch_taken_i,
  input  logic [31:0]      predict_branch_pc_i,
  input  logic             resolve_valid_i,
  input  logic [31:0]      resolve_pc_i,
  input  logic             resolve_taken_i,
  input  logic [31:0]      resolve_target_i,
  input  logic             flush_i,
  input  logic             clear_i,
  output logic [CNT_W-1:0] branch_cnt_o,
  output logic [CNT_W-1:0] mispredict_cnt_o,
  output logic [CNT_W-1:0] dir_miss_cnt_o,
  output logic [CNT_W-1:0] tgt_miss_cnt_o,
  output logic [CNT_W-1:0] orphan_cnt_o,
  output logic [OCC_W-1:0] occupancy_o,
  output logic             overflow_o,
  output logic             mispredict_o,
  output logic [31:0]      mispredict_pc_o
);

  localparam int PTR_W = $clog2(DEPTH);

  localparam logic [4:0] OP_BRANCH = 5'b11000;
  localparam logic [4:0] OP_JAL    = 5'b11011;
  localparam logic [4:0] OP_JALR   = 5'b11001;

  logic [31:0]      ent_pc    [DEPTH];
  logic [31:0]      ent_tgt   [DEPTH];
  logic [DEPTH-1:0] ent_taken;

  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [OCC_W-1:0] occ;

  logic        is_ctrl;
  logic        push_req;
  logic        push_ok;
  logic        full;
  logic        empty;
  logic        match;
  logic        dir_miss;
  logic        tgt_miss;
  logic        mispredict;
  logic        orphan;
  logic        overflow_set;
  logic [31:0] head_pc;
  logic [31:0] head_tgt;
  logic        head_taken;

  // Saturating increment: a counter pinned at all-ones stays there.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
    logic [CNT_W-1:0] r;
    r = v;
    if (en && (v != {CNT_W{1'b1}})) r = v + {{(CNT_W-1){1'b0}}, 1'b1};
    return r;
  endfunction

  // Decode fetch, look at the FIFO head and classify this cycle's resolution.
  always_comb begin
    is_ctrl      = (fetch_rdata_i[1:0] == 2'b11) &&
                   ((fetch_rdata_i[6:2] == OP_BRANCH) ||
                    (fetch_rdata_i[6:2] == OP_JAL) ||
                    (fetch_rdata_i[6:2] == OP_JALR));
    empty        = (occ == '0);
    full         = (occ == OCC_W'(DEPTH));
    head_pc      = ent_pc[rd_ptr];
    head_tgt     = ent_tgt[rd_ptr];
    head_taken   = ent_taken[rd_ptr];
    push_req     = fetch_valid_i && is_ctrl && !flush_i;
    match        = resolve_valid_i && !empty && (head_pc == resolve_pc_i);
    orphan       = resolve_valid_i && !match;
    // A pop in the same cycle frees a slot, so a push at full still fits.
    push_ok      = push_req && (!full || match);
    overflow_set = push_req && full && !match;
    dir_miss     = match && (head_taken != resolve_taken_i);
    tgt_miss     = match && head_taken && resolve_taken_i && (head_tgt != resolve_target_i);
    mispredict   = dir_miss || tgt_miss;
  end

  // Entry storage; only valid slots are ever read, so no reset is needed.
  always_ff @(posedge clk_i) begin
    if (push_ok) begin
      ent_pc[wr_ptr]    <= fetch_pc_i;
      ent_tgt[wr_ptr]   <= predict_branch_pc_i;
      ent_taken[wr_ptr] <= predict_branch_taken_i;
    end
  end

  // Pointers and occupancy; flush empties the FIFO after the current resolve is scored.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      occ    <= '0;
    end else if (flush_i) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      occ    <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      if (match)   rd_ptr <= rd_ptr + PTR_W'(1);
      if (push_ok && !match)      occ <= occ + OCC_W'(1);
      else if (!push_ok && match) occ <= occ - OCC_W'(1);
    end
  end

  // Statistics counters and sticky overflow; clear takes priority over any increment.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      branch_cnt_o     <= '0;
      mispredict_cnt_o <= '0;
      dir_miss_cnt_o   <= '0;
      tgt_miss_cnt_o   <= '0;
      orphan_cnt_o     <= '0;
      overflow_o       <= 1'b0;
    end else if (clear_i) begin
      branch_cnt_o     <= '0;
      mispredict_cnt_o <= '0;
      dir_miss_cnt_o   <= '0;
      tgt_miss_cnt_o   <= '0;
      orphan_cnt_o     <= '0;
      overflow_o       <= 1'b0;
    end else begin
      branch_cnt_o     <= sat_inc(branch_cnt_o, match);
      mispredict_cnt_o <= sat_inc(mispredict_cnt_o, mispredict);
      dir_miss_cnt_o   <= sat_inc(dir_miss_cnt_o, dir_miss);
      tgt_miss_cnt_o   <= sat_inc(tgt_miss_cnt_o, tgt_miss);
      orphan_cnt_o     <= sat_inc(orphan_cnt_o, orphan);
      if (overflow_set) overflow_o <= 1'b1;
    end
  end

  // Mispredict event stream: one-cycle pulse plus the PC of the latest miss.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mispredict_o    <= 1'b0;
      mispredict_pc_o <= '0;
    end else begin
      mispredict_o <= mispredict;
      if (mispredict) mispredict_pc_o <= head_pc;
    end
  end

  assign occupancy_o = occ;

endmodule

// File: tb/tb_dr32e_bp_accuracy_monitor.sv
// Directed bench for dr32e_bp_accuracy_monitor. A behavioural model computes
// the expected outputs for every driven cycle and queues them; they are popped
// and compared once the DUT has taken the clock edge. A second instance with
// 4-bit counters shares the stimulus to exercise counter saturation.
module tb_dr32e_bp_accuracy_monitor;

  localparam int DEPTH = 4;
  localparam int OCC_W = $clog2(DEPTH + 1);

  localparam logic [31:0] W_BEQ  = 32'h0000_0063;
  localparam logic [31:0] W_JAL  = 32'h0000_006F;
  localparam logic [31:0] W_JALR = 32'h0000_0067;
  localparam logic [31:0] W_ADDI = 32'h0000_0013;
  localparam logic [31:0] W_C16  = 32'h0000_0060;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic [31:0] fetch_rdata_i;
  logic [31:0] fetch_pc_i;
  logic        fetch_valid_i;
  logic        predict_branch_taken_i;
  logic [31:0] predict_branch_pc_i;
  logic        resolve_valid_i;
  logic [31:0] resolve_pc_i;
  logic        resolve_taken_i;
  logic [31:0] resolve_target_i;
  logic        flush_i;
  logic        clear_i;

  logic [31:0]      branch_cnt_o, mispredict_cnt_o, dir_miss_cnt_o, tgt_miss_cnt_o, orphan_cnt_o;
  logic [OCC_W-1:0] occupancy_o;
  logic             overflow_o, mispredict_o;
  logic [31:0]      mispredict_pc_o;

  logic [3:0]       s_branch_cnt, s_mis_cnt, s_dir_cnt, s_tgt_cnt, s_orph_cnt;
  logic [OCC_W-1:0] s_occ;
  logic             s_ovf, s_mp;
  logic [31:0]      s_mppc;

  dr32e_bp_accuracy_monitor #(.DEPTH(DEPTH), .CNT_W(32)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .fetch_rdata_i(fetch_rdata_i), .fetch_pc_i(fetch_pc_i), .fetch_valid_i(fetch_valid_i),
    .predict_branch_taken_i(predict_branch_taken_i), .predict_branch_pc_i(predict_branch_pc_i),
    .resolve_valid_i(resolve_valid_i), .resolve_pc_i(resolve_pc_i),
    .resolve_taken_i(resolve_taken_i), .resolve_target_i(resolve_target_i),
    .flush_i(flush_i), .clear_i(clear_i),
    .branch_cnt_o(branch_cnt_o), .mispredict_cnt_o(mispredict_cnt_o),
    .dir_miss_cnt_o(dir_miss_cnt_o), .tgt_miss_cnt_o(tgt_miss_cnt_o),
    .orphan_cnt_o(orphan_cnt_o), .occupancy_o(occupancy_o), .overflow_o(overflow_o),
    .mispredict_o(mispredict_o), .mispredict_pc_o(mispredict_pc_o)
  );

  dr32e_bp_accuracy_monitor #(.DEPTH(DEPTH), .CNT_W(4)) dut_small (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .fetch_rdata_i(fetch_rdata_i), .fetch_pc_i(fetch_pc_i), .fetch_valid_i(fetch_valid_i),
    .predict_branch_taken_i(predict_branch_taken_i), .predict_branch_pc_i(predict_branch_pc_i),
    .resolve_valid_i(resolve_valid_i), .resolve_pc_i(resolve_pc_i),
    .resolve_taken_i(resolve_taken_i), .resolve_target_i(resolve_target_i),
    .flush_i(flush_i), .clear_i(clear_i),
    .branch_cnt_o(s_branch_cnt), .mispredict_cnt_o(s_mis_cnt),
    .dir_miss_cnt_o(s_dir_cnt), .tgt_miss_cnt_o(s_tgt_cnt),
    .orphan_cnt_o(s_orph_cnt), .occupancy_o(s_occ), .overflow_o(s_ovf),
    .mispredict_o(s_mp), .mispredict_pc_o(s_mppc)
  );

  // Free-running core clock.
  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [31:0] pc;
    logic        taken;
    logic [31:0] tgt;
  } entry_t;

  typedef struct {
    logic [31:0]      br, mis, dir, tgt, orph;
    logic [3:0]       br_s;
    logic [OCC_W-1:0] occ;
    logic             ovf, mp;
    logic [31:0]      mppc;
  } exp_t;

  entry_t tq[$];
  exp_t   exp_q[$];

  logic [31:0] m_br, m_mis, m_dir, m_tgt, m_orph, m_mppc;
  logic [3:0]  m_br_s;
  logic        m_ovf, m_mp;

  int n_assert = 0;
  int n_fail   = 0;

  function automatic logic [31:0] inc32(input logic [31:0] v, input logic en);
    return (en && v != 32'hFFFF_FFFF) ? v + 32'd1 : v;
  endfunction

  function automatic logic [3:0] inc4(input logic [3:0] v, input logic en);
    return (en && v != 4'hF) ? v + 4'd1 : v;
  endfunction

  function automatic logic is_ctrl(input logic [31:0] w);
    return (w[1:0] == 2'b11) && (w[6:2] == 5'b11000 || w[6:2] == 5'b11011 || w[6:2] == 5'b11001);
  endfunction

  task automatic check1(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv)
    else begin
      n_fail++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic reset_model();
    tq.delete();
    m_br = 0; m_mis = 0; m_dir = 0; m_tgt = 0; m_orph = 0; m_mppc = 0;
    m_br_s = 0; m_ovf = 0; m_mp = 0;
  endtask

  task automatic set_idle();
    fetch_valid_i = 0; fetch_rdata_i = 0; fetch_pc_i = 0;
    predict_branch_taken_i = 0; predict_branch_pc_i = 0;
    resolve_valid_i = 0; resolve_pc_i = 0; resolve_taken_i = 0; resolve_target_i = 0;
    flush_i = 0; clear_i = 0;
  endtask

  task automatic set_fetch(input logic [31:0] w, input logic [31:0] pc, input logic t, input logic [31:0] tgt);
    fetch_valid_i = 1; fetch_rdata_i = w; fetch_pc_i = pc;
    predict_branch_taken_i = t; predict_branch_pc_i = tgt;
  endtask

  task automatic set_resolve(input logic [31:0] pc, input logic t, input logic [31:0] tgt);
    resolve_valid_i = 1; resolve_pc_i = pc; resolve_taken_i = t; resolve_target_i = tgt;
  endtask

  task automatic checkOutput();
    exp_t e;
    e = exp_q.pop_front();
    check1("branch_cnt", branch_cnt_o, e.br);
    check1("mispredict_cnt", mispredict_cnt_o, e.mis);
    check1("dir_miss_cnt", dir_miss_cnt_o, e.dir);
    check1("tgt_miss_cnt", tgt_miss_cnt_o, e.tgt);
    check1("orphan_cnt", orphan_cnt_o, e.orph);
    check1("occupancy", 32'(occupancy_o), 32'(e.occ));
    check1("overflow", 32'(overflow_o), 32'(e.ovf));
    check1("mispredict", 32'(mispredict_o), 32'(e.mp));
    check1("mispredict_pc", mispredict_pc_o, e.mppc);
    check1("branch_cnt_sat4", 32'(s_branch_cnt), 32'(e.br_s));
  endtask

  // Score the currently driven inputs in the model, queue the expectation,
  // take one clock edge and compare.
  task automatic applyStimulus();
    entry_t h;
    logic   match, dmiss, tmiss, mp, orph, push;
    exp_t   e;
    match = resolve_valid_i && (tq.size() > 0) && (tq[0].pc == resolve_pc_i);
    h     = '{pc: 0, taken: 0, tgt: 0};
    if (tq.size() > 0) h = tq[0];
    dmiss = match && (h.taken != resolve_taken_i);
    tmiss = match && h.taken && resolve_taken_i && (h.tgt != resolve_target_i);
    mp    = dmiss || tmiss;
    orph  = resolve_valid_i && !match;
    push  = fetch_valid_i && is_ctrl(fetch_rdata_i) && !flush_i;
    if (match) void'(tq.pop_front());
    if (flush_i) tq.delete();
    else if (push) begin
      if (tq.size() < DEPTH) tq.push_back('{pc: fetch_pc_i, taken: predict_branch_taken_i, tgt: predict_branch_pc_i});
      else if (!clear_i) m_ovf = 1;
    end
    if (clear_i) begin
      m_br = 0; m_mis = 0; m_dir = 0; m_tgt = 0; m_orph = 0; m_br_s = 0; m_ovf = 0;
    end else begin
      m_br   = inc32(m_br, match);
      m_mis  = inc32(m_mis, mp);
      m_dir  = inc32(m_dir, dmiss);
      m_tgt  = inc32(m_tgt, tmiss);
      m_orph = inc32(m_orph, orph);
      m_br_s = inc4(m_br_s, match);
    end
    m_mp = mp;
    if (mp) m_mppc = h.pc;
    e.br = m_br; e.mis = m_mis; e.dir = m_dir; e.tgt = m_tgt; e.orph = m_orph;
    e.br_s = m_br_s; e.occ = OCC_W'(tq.size()); e.ovf = m_ovf; e.mp = m_mp; e.mppc = m_mppc;
    exp_q.push_back(e);
    @(posedge clk_i);
    #1;
    checkOutput();
    set_idle();
  endtask

  initial begin
    set_idle();
    reset_model();
    rst_ni = 0;
    repeat (2) @(posedge clk_i);
    #1;
    check1("reset_occupancy", 32'(occupancy_o), 32'd0);
    check1("reset_branch_cnt", branch_cnt_o, 32'd0);
    check1("reset_mispredict_pc", mispredict_pc_o, 32'd0);
    rst_ni = 1;
    applyStimulus();

    $display("[TB] correct BEQ prediction");
    set_fetch(W_BEQ, 32'h100, 1, 32'h120); applyStimulus();
    set_resolve(32'h100, 1, 32'h120);      applyStimulus();
    applyStimulus();

    $display("[TB] JAL direction miss");
    set_fetch(W_JAL, 32'h200, 0, 32'h0);   applyStimulus();
    set_resolve(32'h200, 1, 32'h300);      applyStimulus();
    applyStimulus();

    $display("[TB] JALR target miss");
    set_fetch(W_JALR, 32'h400, 1, 32'h500); applyStimulus();
    set_resolve(32'h400, 1, 32'h504);       applyStimulus();
    applyStimulus();

    $display("[TB] non-control words are not tracked");
    set_fetch(W_ADDI, 32'h480, 1, 32'h0); applyStimulus();
    set_fetch(W_C16, 32'h484, 1, 32'h0);  applyStimulus();
    fetch_valid_i = 0; fetch_rdata_i = W_BEQ; applyStimulus();

    $display("[TB] fill, overflow, push+pop at full");
    for (int i = 0; i < 5; i++) begin
      set_fetch(W_BEQ, 32'(i * 4), 1, 32'(i * 4 + 32'h40)); applyStimulus();
    end
    set_fetch(W_BEQ, 32'h14, 1, 32'h54);
    set_resolve(32'h0, 1, 32'h40); applyStimulus();
    set_resolve(32'h4, 1, 32'h44); applyStimulus();
    set_resolve(32'h8, 1, 32'h48); applyStimulus();
    set_resolve(32'hC, 1, 32'h4C); applyStimulus();
    set_fetch(W_BEQ, 32'h18, 0, 32'h0);
    set_resolve(32'h14, 1, 32'h54); applyStimulus();
    set_fetch(W_JAL, 32'h1C, 1, 32'h80);
    set_resolve(32'h18, 0, 32'h1C); applyStimulus();
    set_resolve(32'h1C, 1, 32'h80); applyStimulus();

    $display("[TB] orphans");
    set_resolve(32'h600, 1, 32'h700); applyStimulus();
    set_fetch(W_BEQ, 32'h610, 1, 32'h620); applyStimulus();
    set_resolve(32'h614, 1, 32'h620); applyStimulus();
    set_resolve(32'h610, 1, 32'h620); applyStimulus();

    $display("[TB] flush with resolve and push");
    set_fetch(W_BEQ, 32'h700, 1, 32'h710); applyStimulus();
    set_fetch(W_BEQ, 32'h704, 0, 32'h0);   applyStimulus();
    set_fetch(W_BEQ, 32'h708, 1, 32'h718); applyStimulus();
    set_fetch(W_BEQ, 32'h70C, 1, 32'h71C);
    set_resolve(32'h700, 1, 32'h710);
    flush_i = 1; applyStimulus();
    set_resolve(32'h704, 0, 32'h0); applyStimulus();

    $display("[TB] clear against a mispredict");
    set_fetch(W_BEQ, 32'h800, 0, 32'h0); applyStimulus();
    set_resolve(32'h800, 1, 32'h840);
    clear_i = 1; applyStimulus();
    applyStimulus();

    $display("[TB] saturation of the 4-bit instance");
    set_fetch(W_BEQ, 32'h900, 1, 32'h940); applyStimulus();
    for (int i = 0; i < 16; i++) begin
      set_fetch(W_BEQ, 32'h904 + 32'(i * 4), 1, 32'h944 + 32'(i * 4));
      set_resolve(32'h900 + 32'(i * 4), 1, 32'h940 + 32'(i * 4));
      applyStimulus();
    end
    set_resolve(32'h940, 1, 32'h980); applyStimulus();

    $display("[TB] reset mid-operation");
    set_fetch(W_BEQ, 32'hA00, 1, 32'hA40); applyStimulus();
    set_fetch(W_BEQ, 32'hA04, 0, 32'h0);   applyStimulus();
    set_fetch(W_BEQ, 32'hA08, 0, 32'h0);   applyStimulus();
    set_resolve(32'hA00, 0, 32'h0);        applyStimulus();
    #2;
    rst_ni = 0;
    #1;
    reset_model();
    check1("async_reset_occupancy", 32'(occupancy_o), 32'd0);
    check1("async_reset_branch_cnt", branch_cnt_o, 32'd0);
    check1("async_reset_mispredict_pc", mispredict_pc_o, 32'd0);
    @(posedge clk_i);
    #1;
    rst_ni = 1;
    applyStimulus();
    set_fetch(W_BEQ, 32'hB00, 1, 32'hB40); applyStimulus();
    set_resolve(32'hB00, 1, 32'hB44);      applyStimulus();
    applyStimulus();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
